bbox_scanner: RTL and testbench

//  Rasterizer front end directly upstream of within_triangle. Accepts one triangle per

---
 rtl/bbox_scanner.sv | 88 ++++++++
 tb/tb_bbox_scanner.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bbox_scanner.sv
// bbox_scanner: latches a triangle, then streams every point of its bounding box in raster order.
// Optional BBOX_CLIP_EN clips the box to the screen and drops boxes that start off-screen.
module bbox_scanner #(
  parameter int MAX_RESOLUTION_X = 1920,
  parameter int MAX_RESOLUTION_Y = 1080,
  localparam int XW = $clog2(MAX_RESOLUTION_X),
  localparam int YW = $clog2(MAX_RESOLUTION_Y)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tri_valid,
  output logic          tri_ready,
  input  logic [XW-1:0] tri_p1_x,
  input  logic [YW-1:0] tri_p1_y,
  input  logic [XW-1:0] tri_p2_x,
  input  logic [YW-1:0] tri_p2_y,
  input  logic [XW-1:0] tri_p3_x,
  input  logic [YW-1:0] tri_p3_y,
  output logic [XW-1:0] v_p1_x,
  output logic [YW-1:0] v_p1_y,
  output logic [XW-1:0] v_p2_x,
  output logic [YW-1:0] v_p2_y,
  output logic [XW-1:0] v_p3_x,
  output logic [YW-1:0] v_p3_y,
  output logic          pt_valid,
  input  logic          pt_ready,
  output logic [XW-1:0] pt_x,
  output logic [YW-1:0] pt_y,
  output logic          pt_last,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;
  state_t state, state_next;
  logic [XW-1:0] min_x, max_x, cur_x, bx_min, bx_max;
  logic [YW-1:0] max_y, cur_y, by_min, by_max;
  logic empty;
  always_comb begin
    bx_min = v_p1_x < v_p2_x ? v_p1_x : v_p2_x;
    bx_min = v_p3_x < bx_min ? v_p3_x : bx_min;
    bx_max = v_p1_x > v_p2_x ? v_p1_x : v_p2_x;
    bx_max = v_p3_x > bx_max ? v_p3_x : bx_max;
    by_min = v_p1_y < v_p2_y ? v_p1_y : v_p2_y;
    by_min = v_p3_y < by_min ? v_p3_y : by_min;
    by_max = v_p1_y > v_p2_y ? v_p1_y : v_p2_y;
    by_max = v_p3_y > by_max ? v_p3_y : by_max;
`ifdef BBOX_CLIP_EN
    empty  = bx_min > XW'(MAX_RESOLUTION_X - 1) || by_min > YW'(MAX_RESOLUTION_Y - 1);
    bx_max = bx_max > XW'(MAX_RESOLUTION_X - 1) ? XW'(MAX_RESOLUTION_X - 1) : bx_max;
    by_max = by_max > YW'(MAX_RESOLUTION_Y - 1) ? YW'(MAX_RESOLUTION_Y - 1) : by_max;
`else
    empty  = 1'b0;
`endif
  end
  assign tri_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign pt_valid  = state == SCAN;
  assign pt_x      = cur_x;
  assign pt_y      = cur_y;
  assign pt_last   = pt_valid && cur_x == max_x && cur_y == max_y;
  always_comb begin
    state_next = state == IDLE  ? (tri_valid ? SETUP : IDLE) :
                 state == SETUP ? (empty ? IDLE : SCAN) :
                 (pt_ready && pt_last ? IDLE : SCAN);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v_p1_x, v_p1_y, v_p2_x, v_p2_y, v_p3_x, v_p3_y} <= '0;
      {min_x, max_x, max_y, cur_x, cur_y} <= '0;
    end else begin
      if (tri_valid && tri_ready)
        {v_p1_x, v_p1_y, v_p2_x, v_p2_y, v_p3_x, v_p3_y} <=
          {tri_p1_x, tri_p1_y, tri_p2_x, tri_p2_y, tri_p3_x, tri_p3_y};
      if (state == SETUP) begin
        min_x <= bx_min;
        max_x <= bx_max;
        max_y <= by_max;
        cur_x <= bx_min;
        cur_y <= by_min;
      end else if (pt_valid && pt_ready && !pt_last) begin
        cur_x <= cur_x == max_x ? min_x : cur_x + 1'b1;
        cur_y <= cur_x == max_x ? cur_y + 1'b1 : cur_y;
      end
    end
  end
endmodule

// File: tb/tb_bbox_scanner.sv
// tb_bbox_scanner: table-driven and randomized check of bbox_scanner against a point-list model.
module tb_bbox_scanner;
  logic clk, rst, tri_valid, tri_ready, pt_valid, pt_ready, pt_last, busy;
  logic [10:0] tri_p1_x, tri_p1_y, tri_p2_x, tri_p2_y, tri_p3_x, tri_p3_y;
  logic [10:0] v_p1_x, v_p1_y, v_p2_x, v_p2_y, v_p3_x, v_p3_y, pt_x, pt_y;
  int n_tests = 0, n_fail = 0;

  bbox_scanner dut (
    .clk(clk), .rst(rst), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_p1_x(tri_p1_x), .tri_p1_y(tri_p1_y), .tri_p2_x(tri_p2_x), .tri_p2_y(tri_p2_y),
    .tri_p3_x(tri_p3_x), .tri_p3_y(tri_p3_y),
    .v_p1_x(v_p1_x), .v_p1_y(v_p1_y), .v_p2_x(v_p2_x), .v_p2_y(v_p2_y),
    .v_p3_x(v_p3_x), .v_p3_y(v_p3_y),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
    .pt_last(pt_last), .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit vp_eq(input int x1, y1, x2, y2, x3, y3);
    return v_p1_x == x1 && v_p1_y == y1 && v_p2_x == x2 && v_p2_y == y2 &&
           v_p3_x == x3 && v_p3_y == y3;
  endfunction

  // mode: 0 always ready, 1 alternate stall/accept, 2 random ready, 3 ready + junk triangle offered during scan
  task automatic run_tri(input int x1, y1, x2, y2, x3, y3, input int mode, input int exp_n);
    int xs[3], ys[3], qx[$], qy[$];
    int lo_x, hi_x, lo_y, hi_y, n, got, cyc, hx, hy, hl;
    bit stalled, rdy, empty;
    xs = '{x1, x2, x3};
    ys = '{y1, y2, y3};
    lo_x = xs[0]; hi_x = xs[0]; lo_y = ys[0]; hi_y = ys[0];
    for (int i = 1; i < 3; i++) begin
      if (xs[i] < lo_x) lo_x = xs[i];
      if (xs[i] > hi_x) hi_x = xs[i];
      if (ys[i] < lo_y) lo_y = ys[i];
      if (ys[i] > hi_y) hi_y = ys[i];
    end
    empty = 0;
`ifdef BBOX_CLIP_EN
    if (hi_x > 1919) hi_x = 1919;
    if (hi_y > 1079) hi_y = 1079;
    empty = lo_x > 1919 || lo_y > 1079;
`endif
    if (!empty)
      for (int y = lo_y; y <= hi_y; y++)
        for (int x = lo_x; x <= hi_x; x++) begin
          qx.push_back(x);
          qy.push_back(y);
        end
    n = qx.size();
    if (exp_n < 0) exp_n = n;
    {tri_p1_x, tri_p1_y, tri_p2_x, tri_p2_y, tri_p3_x, tri_p3_y} =
      {11'(x1), 11'(y1), 11'(x2), 11'(y2), 11'(x3), 11'(y3)};
    tri_valid = 1;
    pt_ready = 1;
    chk("tri_ready_idle", tri_ready, 1);
    @(posedge clk); #1;
    if (mode == 3)
      {tri_p1_x, tri_p1_y, tri_p2_x, tri_p2_y, tri_p3_x, tri_p3_y} =
        {11'(x1 ^ 5), 11'(y1 ^ 3), 11'(x2 ^ 6), 11'(y2 ^ 1), 11'(x3 ^ 2), 11'(y3 ^ 7)};
    else
      tri_valid = 0;
    chk("setup_busy", busy, 1);
    chk("setup_pt_valid", pt_valid, 0);
    chk("setup_tri_ready", tri_ready, 0);
    chk("v_latch", vp_eq(x1, y1, x2, y2, x3, y3), 1);
    @(posedge clk); #1;
    got = 0; cyc = 0; stalled = 0; hx = 0; hy = 0; hl = 0;
    while (qx.size() > 0 && cyc < 5000) begin
      if (stalled) chk("stall_hold", pt_x == hx && pt_y == hy && pt_last == hl, 1);
      chk("pt_valid", pt_valid, 1);
      chk("pt_xy", pt_x * 4096 + pt_y, qx[0] * 4096 + qy[0]);
      chk("pt_last", pt_last, qx.size() == 1);
      chk("v_hold", vp_eq(x1, y1, x2, y2, x3, y3), 1);
      if (mode == 3) chk("tri_ready_scan", tri_ready, 0);
      rdy = mode == 1 ? cyc % 2 == 1 : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b1;
      pt_ready = rdy;
      stalled = !rdy;
      hx = pt_x; hy = pt_y; hl = pt_last;
      if (rdy) begin
        void'(qx.pop_front());
        void'(qy.pop_front());
        got++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    if (cyc >= 5000) chk("scan_timeout", 0, 1);
    tri_valid = 0;
    chk("done_tri_ready", tri_ready, 1);
    chk("done_busy", busy, 0);
    chk("done_pt_valid", pt_valid, 0);
    chk("beats", got, exp_n);
  endtask

  typedef struct {
    int x1, y1, x2, y2, x3, y3, mode, exp_n;
  } vec_t;
  vec_t tv[8];

  initial begin
    rst = 0; tri_valid = 0; pt_ready = 0;
    {tri_p1_x, tri_p1_y, tri_p2_x, tri_p2_y, tri_p3_x, tri_p3_y} = '0;
    #2 rst = 1;
    #1;
    chk("rst_pt_valid", pt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pt_last", pt_last, 0);
    chk("rst_pt_xy", pt_x * 4096 + pt_y, 0);
    chk("rst_v", vp_eq(0, 0, 0, 0, 0, 0), 1);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    chk("rst_tri_ready", tri_ready, 1);

    tv[0] = '{2, 3, 4, 3, 2, 5, 0, 9};
    tv[1] = '{7, 7, 7, 7, 7, 7, 0, 1};
    tv[2] = '{2, 3, 4, 3, 2, 5, 1, 9};
    tv[3] = '{2, 3, 4, 3, 2, 5, 3, 9};
    tv[4] = '{4, 5, 2, 3, 4, 3, 2, 9};
    tv[5] = '{10, 0, 10, 6, 10, 3, 0, 7};
`ifdef BBOX_CLIP_EN
    tv[6] = '{1917, 0, 2000, 0, 1917, 1, 0, 6};
    tv[7] = '{1950, 5, 1960, 5, 1955, 6, 0, 0};
`else
    tv[6] = '{1917, 0, 2000, 0, 1917, 1, 0, 168};
    tv[7] = '{1950, 5, 1960, 5, 1955, 6, 0, 22};
`endif
    for (int i = 0; i < 8; i++)
      run_tri(tv[i].x1, tv[i].y1, tv[i].x2, tv[i].y2, tv[i].x3, tv[i].y3, tv[i].mode, tv[i].exp_n);

    // abort a scan with reset after four accepted points
    {tri_p1_x, tri_p1_y, tri_p2_x, tri_p2_y, tri_p3_x, tri_p3_y} =
      {11'd2, 11'd3, 11'd4, 11'd3, 11'd2, 11'd5};
    tri_valid = 1; pt_ready = 1;
    @(posedge clk); #1 tri_valid = 0;
    @(posedge clk); #1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_point", pt_x * 4096 + pt_y, 3 * 4096 + 4);
    rst = 1;
    #1;
    chk("abort_pt_valid", pt_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_pt_last", pt_last, 0);
    chk("abort_v", vp_eq(0, 0, 0, 0, 0, 0), 1);
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    run_tri(0, 0, 1, 0, 0, 1, 0, 4);

    for (int i = 0; i < 25; i++) begin
      int bx, by;
      bx = $urandom_range(0, 2030);
      by = $urandom_range(0, 2030);
      run_tri(bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
              bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
              bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
              $urandom_range(0, 3), -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
